// File: rtl/dda_ctrl_regbank.sv
// Avalon-MM control/status register bank for the DDA solver: parameters, initial
// values, on-chip step generation, timed solver reset and atomic state snapshot.
module dda_ctrl_regbank #(
    parameter int NUM_PARAMS = 3,
    parameter int NUM_STATES = 3,
    parameter int RST_CYCLES = 4,
    parameter int ADDR_W     = 5
) (
    input  logic                     clk,
    input  logic                     reset_n,
    input  logic [ADDR_W-1:0]        avs_address,
    input  logic                     avs_read,
    input  logic                     avs_write,
    input  logic [31:0]              avs_writedata,
    output logic [31:0]              avs_readdata,
    input  logic [NUM_STATES*32-1:0] state_in,
    output logic [NUM_PARAMS*32-1:0] param_out,
    output logic [NUM_STATES*32-1:0] init_out,
    output logic                     solver_reset,
    output logic                     step_en,
    output logic                     busy
);
    typedef enum logic [1:0] {
        S_IDLE      = 2'd0,
        S_RUN       = 2'd1,
        S_BURST     = 2'd2,
        S_RESETTING = 2'd3
    } state_t;

    state_t                  state_reg, state_next;
    logic [31:0]             div_reg, burst_len_reg, step_count_reg;
    logic [31:0]             burst_remain_reg, div_cnt_reg;
    logic [7:0]              rst_cnt_reg;
    logic                    snap_valid_reg;
    logic [NUM_STATES*32-1:0] snap_bus;
    logic [31:0]             readdata_reg, read_mux;
    logic [31:0]             addr;

    logic ctrl_wr, ctrl_srst, ctrl_run, ctrl_burst, ctrl_stop, ctrl_snap;
    logic stepping, rst_done, restart_div;

    assign addr        = 32'(avs_address);
    assign ctrl_wr     = avs_write && (addr == 32'd0);
    assign ctrl_srst   = ctrl_wr && avs_writedata[2];
    assign ctrl_run    = ctrl_wr && avs_writedata[0];
    assign ctrl_burst  = ctrl_wr && avs_writedata[1] && (burst_len_reg != 32'd0);
    assign ctrl_stop   = ctrl_wr && (avs_writedata[2:0] == 3'd0);
    assign ctrl_snap   = ctrl_wr && avs_writedata[3];

    assign stepping     = (state_reg == S_RUN) || (state_reg == S_BURST);
    assign step_en      = stepping && (div_cnt_reg == div_reg);
    assign rst_done     = (rst_cnt_reg == 8'(RST_CYCLES - 1));
    // Any CTRL write that (re)enters RUN or BURST realigns the divider phase.
    assign restart_div  = !ctrl_srst && (ctrl_run || ctrl_burst);
    assign solver_reset = (state_reg == S_RESETTING);
    assign busy         = (state_reg != S_IDLE);
    assign avs_readdata = readdata_reg;

    always_comb begin
        state_next = state_reg;
        if (state_reg == S_RESETTING && rst_done)
            state_next = S_IDLE;
        if (state_reg == S_BURST && step_en && burst_remain_reg == 32'd1)
            state_next = S_IDLE;
        if (ctrl_srst)
            state_next = S_RESETTING;
        else if (ctrl_run)
            state_next = S_RUN;
        else if (ctrl_burst)
            state_next = S_BURST;
        else if (ctrl_stop && stepping)
            state_next = S_IDLE;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg        <= S_RESETTING;
            rst_cnt_reg      <= '0;
            div_cnt_reg      <= '0;
            step_count_reg   <= '0;
            burst_remain_reg <= '0;
            snap_valid_reg   <= 1'b0;
            div_reg          <= '0;
            burst_len_reg    <= '0;
            readdata_reg     <= '0;
        end else begin
            state_reg <= state_next;

            if (ctrl_srst)
                rst_cnt_reg <= '0;
            else if (state_reg == S_RESETTING && !rst_done)
                rst_cnt_reg <= rst_cnt_reg + 8'd1;

            if (restart_div || step_en || !stepping)
                div_cnt_reg <= '0;
            else
                div_cnt_reg <= div_cnt_reg + 32'd1;

            if (ctrl_srst || state_reg == S_RESETTING)
                step_count_reg <= '0;
            else if (step_en)
                step_count_reg <= step_count_reg + 32'd1;

            if (!ctrl_srst && !ctrl_run && ctrl_burst)
                burst_remain_reg <= burst_len_reg;
            else if (ctrl_stop && stepping)
                burst_remain_reg <= '0;
            else if (step_en && state_reg == S_BURST && burst_remain_reg != 32'd0)
                burst_remain_reg <= burst_remain_reg - 32'd1;

            if (ctrl_srst)
                snap_valid_reg <= 1'b0;
            else if (ctrl_snap)
                snap_valid_reg <= 1'b1;

            if (avs_write && addr == 32'd2)
                div_reg <= avs_writedata;
            if (avs_write && addr == 32'd3)
                burst_len_reg <= avs_writedata;

            // Registered read sees pre-write contents on a simultaneous write.
            if (avs_read)
                readdata_reg <= read_mux;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_PARAMS; gi++) begin : g_param
            logic [31:0] param_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n)
                    param_reg <= '0;
                else if (avs_write && addr == 32'(8 + gi))
                    param_reg <= avs_writedata;
            end
            assign param_out[32*gi +: 32] = param_reg;
        end

        for (genvar gi = 0; gi < NUM_STATES; gi++) begin : g_state
            logic [31:0] init_reg;
            logic [31:0] snap_reg;
            always_ff @(posedge clk or negedge reset_n) begin
                if (!reset_n) begin
                    init_reg <= '0;
                    snap_reg <= '0;
                end else begin
                    if (avs_write && addr == 32'(16 + gi))
                        init_reg <= avs_writedata;
                    if (ctrl_snap)
                        snap_reg <= state_in[32*gi +: 32];
                end
            end
            assign init_out[32*gi +: 32] = init_reg;
            assign snap_bus[32*gi +: 32] = snap_reg;
        end
    endgenerate

    always_comb begin
        read_mux = '0;
        case (addr)
            32'd1:   read_mux = {28'd0, state_reg, snap_valid_reg, busy};
            32'd2:   read_mux = div_reg;
            32'd3:   read_mux = burst_len_reg;
            32'd4:   read_mux = step_count_reg;
            32'd5:   read_mux = burst_remain_reg;
            default: read_mux = '0;
        endcase
        for (int i = 0; i < NUM_PARAMS; i++)
            if (addr == 32'(8 + i))
                read_mux = param_out[32*i +: 32];
        for (int i = 0; i < NUM_STATES; i++) begin
            if (addr == 32'(16 + i))
                read_mux = init_out[32*i +: 32];
            if (addr == 32'(24 + i))
                read_mux = snap_bus[32*i +: 32];
        end
    end
endmodule

// File: tb/tb_dda_ctrl_regbank.sv
// Bench for dda_ctrl_regbank: event-level reference model compared every cycle,
// plus directed bus transactions with hand-computed expectations.
module tb_dda_ctrl_regbank;
    localparam int NP = 3;
    localparam int NS = 3;
    localparam int RC = 4;
    localparam int AW = 5;

    logic           clk = 1'b0;
    logic           reset_n;
    logic [AW-1:0]  avs_address;
    logic           avs_read;
    logic           avs_write;
    logic [31:0]    avs_writedata;
    logic [31:0]    avs_readdata;
    logic [NS*32-1:0] state_in;
    logic [NP*32-1:0] param_out;
    logic [NS*32-1:0] init_out;
    logic           solver_reset;
    logic           step_en;
    logic           busy;

    int checks = 0;
    int errors = 0;

    dda_ctrl_regbank #(
        .NUM_PARAMS(NP), .NUM_STATES(NS), .RST_CYCLES(RC), .ADDR_W(AW)
    ) dut (
        .clk(clk), .reset_n(reset_n),
        .avs_address(avs_address), .avs_read(avs_read), .avs_write(avs_write),
        .avs_writedata(avs_writedata), .avs_readdata(avs_readdata),
        .state_in(state_in), .param_out(param_out), .init_out(init_out),
        .solver_reset(solver_reset), .step_en(step_en), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Reference model: tracks mode and the absolute edge numbers at which the
    // next step and the end of a reset are due.
    int unsigned cyc;
    int          m_mode;            // 0 idle, 1 run, 2 burst, 3 resetting
    int unsigned m_reset_until;
    int unsigned m_next_step;
    logic [31:0] m_div, m_len, m_count, m_remain, m_rd;
    logic [31:0] m_param [8];
    logic [31:0] m_init  [8];
    logic [31:0] m_snap  [8];
    logic        m_snap_valid;
    int unsigned step_q [$];

    function automatic logic [31:0] model_read(input int a);
        logic [31:0] v;
        v = '0;
        if (a == 1)      v = {28'd0, 2'(m_mode), m_snap_valid, 1'(m_mode != 0)};
        else if (a == 2) v = m_div;
        else if (a == 3) v = m_len;
        else if (a == 4) v = m_count;
        else if (a == 5) v = m_remain;
        else if (a >= 8  && a < 8 + NP)  v = m_param[a-8];
        else if (a >= 16 && a < 16 + NS) v = m_init[a-16];
        else if (a >= 24 && a < 24 + NS) v = m_snap[a-24];
        return v;
    endfunction

    always @(posedge clk or negedge reset_n) begin : model
        int          a;
        logic        stepped;
        logic [31:0] wd;
        if (!reset_n) begin
            cyc = 0; m_mode = 3; m_reset_until = RC; m_next_step = 0;
            m_div = 0; m_len = 0; m_count = 0; m_remain = 0; m_rd = 0;
            m_snap_valid = 1'b0;
            for (int i = 0; i < 8; i++) begin
                m_param[i] = 0; m_init[i] = 0; m_snap[i] = 0;
            end
        end else begin
            cyc++;
            a  = int'(avs_address);
            wd = avs_writedata;
            if (avs_read) m_rd = model_read(a);
            stepped = (m_mode == 1 || m_mode == 2) && (cyc == m_next_step);
            if (m_mode == 3) m_count = 0;
            if (m_mode == 3 && cyc >= m_reset_until) m_mode = 0;
            if (stepped) begin
                m_count++;
                m_next_step = cyc + m_div + 1;
                if (m_mode == 2) begin
                    m_remain--;
                    if (m_remain == 0) m_mode = 0;
                end
            end
            if (avs_write) begin
                if (a == 0) begin
                    if (wd[3]) begin
                        for (int i = 0; i < NS; i++) m_snap[i] = state_in[32*i +: 32];
                        m_snap_valid = 1'b1;
                    end
                    if (wd[2]) begin
                        m_mode = 3; m_reset_until = cyc + RC;
                        m_snap_valid = 1'b0; m_count = 0;
                    end else if (wd[0]) begin
                        m_mode = 1; m_next_step = cyc + m_div + 1;
                    end else if (wd[1]) begin
                        if (m_len != 0) begin
                            m_mode = 2; m_remain = m_len; m_next_step = cyc + m_div + 1;
                        end
                    end else if (m_mode == 1 || m_mode == 2) begin
                        m_mode = 0; m_remain = 0;
                    end
                end
                else if (a == 2) m_div = wd;
                else if (a == 3) m_len = wd;
                else if (a >= 8  && a < 8 + NP)  m_param[a-8]  = wd;
                else if (a >= 16 && a < 16 + NS) m_init[a-16] = wd;
            end
        end
    end

    always @(negedge clk) begin : compare
        logic exp_step;
        exp_step = (m_mode == 1 || m_mode == 2) && (cyc + 1 == m_next_step);
        check("step_en", 32'(step_en), 32'(exp_step));
        check("solver_reset", 32'(solver_reset), 32'(m_mode == 3));
        check("busy", 32'(busy), 32'(m_mode != 0));
        check("readdata", avs_readdata, m_rd);
        for (int i = 0; i < NP; i++) check("param_out", param_out[32*i +: 32], m_param[i]);
        for (int i = 0; i < NS; i++) check("init_out", init_out[32*i +: 32], m_init[i]);
        if (step_en) step_q.push_back(cyc + 1);
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk); #1;
        end
    endtask

    task automatic wr(input int a, input logic [31:0] d);
        avs_address = AW'(a); avs_writedata = d; avs_write = 1'b1;
        @(posedge clk); #1;
        avs_write = 1'b0;
        $display("WR addr=%0d data=0x%08h edge=%0d", a, d, cyc);
    endtask

    task automatic rd(input int a, input logic [31:0] exp, input string name);
        avs_address = AW'(a); avs_read = 1'b1;
        @(posedge clk); #1;
        avs_read = 1'b0;
        $display("RD addr=%0d data=0x%08h edge=%0d", a, avs_readdata, cyc);
        check(name, avs_readdata, exp);
    endtask

    task automatic wait_reset_done(output int n);
        n = 0;
        while (solver_reset && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
    endtask

    initial begin
        int n;
        int unsigned w;
        int unsigned qs;
        reset_n = 1'b0; avs_address = '0; avs_read = 1'b0; avs_write = 1'b0;
        avs_writedata = '0; state_in = '0;
        #22 reset_n = 1'b1;

        // Reset release: solver_reset for exactly RC edges
        wait_reset_done(n);
        check("reset_len", 32'(n), 32'd4);
        check("busy_after_reset", 32'(busy), 32'd0);
        for (int a = 0; a < 32; a++) rd(a, 32'd0, "reset_read");

        // Parameter / initial-value registers
        wr(9, 32'h0002_AAAB);
        wr(16, 32'hFFFF_0000);
        rd(9, 32'h0002_AAAB, "param1_rb");
        rd(16, 32'hFFFF_0000, "init0_rb");
        check("param_out1", param_out[63:32], 32'h0002_AAAB);
        check("init_out0", init_out[31:0], 32'hFFFF_0000);
        rd(11, 32'd0, "unmapped_11");
        rd(20, 32'd0, "unmapped_20");
        rd(0, 32'd0, "ctrl_reads_zero");
        avs_address = AW'(8); avs_writedata = 32'h1234; avs_read = 1'b1; avs_write = 1'b1;
        @(posedge clk); #1;
        avs_read = 1'b0; avs_write = 1'b0;
        $display("RW addr=8 data=0x%08h edge=%0d", avs_readdata, cyc);
        check("rw_pre_write", avs_readdata, 32'd0);
        rd(8, 32'h0000_1234, "rw_post_write");

        // Free-run with DIV=2
        wr(2, 32'd2);
        step_q.delete();
        wr(0, 32'd1);
        w = cyc;
        n = 0;
        while (step_q.size() < 10 && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        wr(0, 32'd0);
        check("run_pulses", 32'(step_q.size()), 32'd10);
        if (step_q.size() >= 10) begin
            check("run_first", step_q[0], w + 3);
            for (int i = 1; i < 10; i++) check("run_spacing", step_q[i] - step_q[i-1], 32'd3);
        end
        tick(8);
        check("run_stopped", 32'(step_q.size()), 32'd10);
        rd(4, 32'd10, "step_count_run");

        // Counted burst
        wr(3, 32'd5);
        wr(2, 32'd0);
        step_q.delete();
        wr(0, 32'd2);
        w = cyc;
        rd(5, 32'd5, "remain_start");
        rd(5, 32'd4, "remain_next");
        tick(8);
        check("burst_pulses", 32'(step_q.size()), 32'd5);
        if (step_q.size() == 5)
            for (int i = 0; i < 5; i++) check("burst_edge", step_q[i], w + 1 + i);
        rd(5, 32'd0, "remain_end");
        rd(1, 32'd0, "status_after_burst");
        rd(4, 32'd15, "step_count_burst");
        wr(3, 32'd0);
        step_q.delete();
        wr(0, 32'd2);
        tick(6);
        check("burst_len0", 32'(step_q.size()), 32'd0);
        rd(1, 32'd0, "status_len0");

        // Snapshot
        state_in = {32'h33, 32'h22, 32'h11};
        wr(0, 32'd8);
        state_in = {32'h99, 32'h88, 32'h77};
        rd(24, 32'h11, "snap0");
        rd(25, 32'h22, "snap1");
        rd(26, 32'h33, "snap2");
        rd(1, 32'h2, "status_snap");
        rd(27, 32'd0, "snap_oob");

        // Solver reset during RUN
        wr(2, 32'd1);
        wr(0, 32'd1);
        tick(5);
        wr(0, 32'd5);
        w = cyc;
        rd(1, 32'hD, "status_resetting");
        rd(4, 32'd0, "step_count_reset");
        wait_reset_done(n);
        check("srst_len", cyc - w, 32'd4);
        rd(1, 32'd0, "status_after_srst");
        qs = step_q.size();
        tick(6);
        check("no_run_after_srst", 32'(step_q.size()), qs);
        rd(4, 32'd0, "step_count_after_srst");

        // SNAP together with SRST
        state_in = {32'h3, 32'h2, 32'hAAAA_0001};
        wr(0, 32'd12);
        rd(24, 32'hAAAA_0001, "snap_with_srst");
        rd(1, 32'hD, "status_snap_srst");
        wait_reset_done(n);
        rd(1, 32'd0, "status_final");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
